// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for up to eight common-anode seven-segment digits. An external,
// already-divided scan clock steps through the digits. Every digit change is preceded by a
// short all-dark blank interval so that the previous digit's segments never ghost onto the next
// anode. The displayed value is captured into a shadow register once per frame, when the digit
// index wraps back to 0, so a frame never mixes old and new data.
//
// Parameters
//   NUM_DIGITS    number of multiplexed digits (1..8)
//   BLANK_CYCLES  anti-ghosting blank length in clk cycles (0..255)
//
// Ports
//   clk         in   sole clock, rising edge
//   rst         in   asynchronous active-high reset
//   scan_clk    in   divided scan clock; sampled as data, never used as a clock
//   data[31:0]  in   eight hex nibbles, nibble k drives digit k
//   dp_mask[7:0] in  bit k lights the decimal point of digit k
//   lz_blank    in   1 = blank leading zeros (digit 0 is always shown)
//   an[7:0]     out  active-low digit anodes
//   seg[7:0]    out  active-low segments, bit 7 = dp, bits 6:0 = g..a
//   frame_done  out  one-cycle pulse at the start of each new scan frame
// ---------------------------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_clk,
    input  logic [31:0] data,
    input  logic [7:0]  dp_mask,
    input  logic        lz_blank,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);

    // FSM encoding
    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;

    localparam logic [7:0] CNT_INIT   = (BLANK_CYCLES == 0) ? 8'd0 : 8'(BLANK_CYCLES - 1);
    localparam logic [2:0] IDX_LAST   = 3'(NUM_DIGITS - 1);
    // Anode bits that belong to real digits; the rest stay dark.
    localparam logic [7:0] DIGIT_MASK = 8'((1 << NUM_DIGITS) - 1);

    // -----------------------------------------------------------------------------------------
    // scan_clk synchroniser and rising-edge detector
    // -----------------------------------------------------------------------------------------
    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic [1:0] prime_q;
    logic       primed;
    logic       tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            prime_q <= 2'd0;
        end else begin
            sync1_q <= scan_clk;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (prime_q != 2'd3) begin
                prime_q <= prime_q + 2'd1;
            end
        end
    end

    // prev_q only holds a real sample three edges after reset release. Until then a high
    // scan_clk level that was already present at release would look like a rising edge,
    // so the edge detector is held off.
    assign primed = (prime_q == 2'd3);
    assign tick   = sync2_q & ~prev_q & primed;

    // -----------------------------------------------------------------------------------------
    // Digit index, blank/show FSM and frame shadow
    // -----------------------------------------------------------------------------------------
    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] shadow_q, shadow_d;
    logic [7:0]  shadow_dp_q, shadow_dp_d;
    logic        frame_done_q, frame_done_d;
    logic        wrap;
    logic [2:0]  idx_next;

    assign wrap     = (idx_q == IDX_LAST);
    assign idx_next = wrap ? 3'd0 : idx_q + 3'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        frame_done_d = 1'b0;

        if (tick) begin
            // A tick wins over blank expiry: always advance and restart the blank.
            idx_d = idx_next;
            if (BLANK_CYCLES == 0) begin
                state_d = ST_SHOW;
                cnt_d   = 8'd0;
            end else begin
                state_d = ST_BLANK;
                cnt_d   = CNT_INIT;
            end
            if (wrap) begin
                shadow_d     = data;
                shadow_dp_d  = dp_mask;
                frame_done_d = 1'b1;
            end
        end else if (state_q == ST_BLANK) begin
            if (cnt_q == 8'd0) begin
                state_d = ST_SHOW;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            cnt_q        <= CNT_INIT;
            idx_q        <= 3'd0;
            shadow_q     <= 32'd0;
            shadow_dp_q  <= 8'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_done = frame_done_q;

    // -----------------------------------------------------------------------------------------
    // Output decode (registered state plus lz_blank only)
    // -----------------------------------------------------------------------------------------
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        hex_glyph = 7'h7F;
        case (v)
            4'h0: hex_glyph = 7'b1000000;
            4'h1: hex_glyph = 7'b1111001;
            4'h2: hex_glyph = 7'b0100100;
            4'h3: hex_glyph = 7'b0110000;
            4'h4: hex_glyph = 7'b0011001;
            4'h5: hex_glyph = 7'b0010010;
            4'h6: hex_glyph = 7'b0000010;
            4'h7: hex_glyph = 7'b1111000;
            4'h8: hex_glyph = 7'b0000000;
            4'h9: hex_glyph = 7'b0010000;
            4'hA: hex_glyph = 7'b0001000;
            4'hB: hex_glyph = 7'b0000011;
            4'hC: hex_glyph = 7'b1000110;
            4'hD: hex_glyph = 7'b0100001;
            4'hE: hex_glyph = 7'b0000110;
            4'hF: hex_glyph = 7'b0001110;
            default: hex_glyph = 7'h7F;
        endcase
    endfunction

    logic [3:0] cur_nibble;
    logic       lz_dark;

    assign cur_nibble = shadow_q[{idx_q, 2'b00} +: 4];

    // Digit is a leading zero when it and every more-significant digit is zero.
    always_comb begin
        lz_dark = lz_blank && (idx_q != 3'd0);
        for (int k = 0; k < 8; k++) begin
            if ((k < NUM_DIGITS) && (3'(k) >= idx_q) && (shadow_q[4*k +: 4] != 4'h0)) begin
                lz_dark = 1'b0;
            end
        end
    end

    always_comb begin
        an  = 8'hFF;
        seg = 8'hFF;
        if ((state_q == ST_SHOW) && !lz_dark) begin
            an  = ~(8'd1 << idx_q) | ~DIGIT_MASK;
            seg = {~shadow_dp_q[idx_q], hex_glyph(cur_nibble)};
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed scenarios followed by randomized scan
// timing, data and resets, all compared against a cycle-level behavioural model.
module tb_seg7_scan_driver;

    localparam int NUM_DIGITS   = 8;
    localparam int BLANK_CYCLES = 4;

    logic        clk;
    logic        rst;
    logic        scan_clk;
    logic [31:0] data;
    logic [7:0]  dp_mask;
    logic        lz_blank;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    seg7_scan_driver #(
        .NUM_DIGITS  (NUM_DIGITS),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scan_clk  (scan_clk),
        .data      (data),
        .dp_mask   (dp_mask),
        .lz_blank  (lz_blank),
        .an        (an),
        .seg       (seg),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int fd_seen  = 0;

    // Reference model: digit index, remaining blank cycles, displayed frame contents and the
    // clk edge numbers at which pending scan edges take effect.
    int         tick_q[$];
    int         m_idx;
    int         m_blank;
    logic [3:0] m_nib[8];
    logic [7:0] m_dp;
    logic       m_fd;
    logic [6:0] glyph[16];

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    task automatic model_reset();
        m_idx   = 0;
        m_blank = BLANK_CYCLES;
        m_dp    = 8'h00;
        m_fd    = 1'b0;
        for (int k = 0; k < 8; k++) m_nib[k] = 4'h0;
        tick_q.delete();
    endtask

    task automatic model_edge();
        edge_cnt++;
        if (rst) return;
        m_fd = 1'b0;
        if (tick_q.size() > 0 && tick_q[0] == edge_cnt) begin
            void'(tick_q.pop_front());
            if (m_idx == NUM_DIGITS - 1) begin
                m_idx = 0;
                m_fd  = 1'b1;
                for (int k = 0; k < 8; k++) m_nib[k] = data[4*k +: 4];
                m_dp = dp_mask;
            end else begin
                m_idx++;
            end
            m_blank = BLANK_CYCLES;
        end else if (m_blank > 0) begin
            m_blank--;
        end
    endtask

    task automatic check_outputs();
        logic [7:0] e_an;
        logic [7:0] e_seg;
        bit         dark;
        e_an  = 8'hFF;
        e_seg = 8'hFF;
        if (m_blank == 0) begin
            dark = lz_blank && (m_idx > 0);
            for (int k = m_idx; k < NUM_DIGITS; k++) if (m_nib[k] != 4'h0) dark = 1'b0;
            if (!dark) begin
                e_an  = ~(8'd1 << m_idx);
                e_seg = {~m_dp[m_idx], glyph[m_nib[m_idx]]};
            end
        end
        check_eq("an", an, e_an);
        check_eq("seg", seg, e_seg);
        check_eq("frame_done", {7'd0, frame_done}, {7'd0, m_fd});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        if (frame_done) fd_seen++;
    endtask

    // A rising scan edge driven now is first sampled on the next clk edge and acted on by the
    // third clk edge from now.
    task automatic scan_rise();
        scan_clk = 1'b1;
        tick_q.push_back(edge_cnt + 3);
    endtask

    task automatic scan_pulse(input int hi, input int lo);
        scan_rise();
        repeat (hi) step();
        scan_clk = 1'b0;
        repeat (lo) step();
    endtask

    // Asserts rst between clk edges, checks the immediate effect, then releases and lets the
    // edge detector settle for three edges.
    task automatic do_reset(input logic hold_scan);
        #2;
        rst      = 1'b1;
        scan_clk = hold_scan;
        #1;
        check_eq("rst_async_an", an, 8'hFF);
        check_eq("rst_async_seg", seg, 8'hFF);
        check_eq("rst_async_fd", {7'd0, frame_done}, 8'd0);
        model_reset();
        step();
        step();
        rst = 1'b0;
        repeat (3) step();
    endtask

    int fd_base;

    initial begin
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst      = 1'b1;
        scan_clk = 1'b0;
        data     = 32'h0;
        dp_mask  = 8'h00;
        lz_blank = 1'b0;
        model_reset();

        // Reset then steady state: blank, then digit 0 showing '0'.
        do_reset(1'b0);
        check_eq("post_rst_blank_seg", seg, 8'hFF);
        step();
        check_eq("post_rst_an", an, 8'hFE);
        check_eq("post_rst_seg", seg, 8'hC0);

        // Full frame.
        data    = 32'h1234ABCD;
        dp_mask = 8'h01;
        fd_base = fd_seen;
        repeat (8) scan_pulse(5, 5);
        check_eq("frame_pulse_count", 8'(fd_seen - fd_base), 8'd1);
        check_eq("frame_d0_an", an, 8'hFE);
        check_eq("frame_d0_seg", seg, 8'h21);
        repeat (7) scan_pulse(5, 5);
        check_eq("frame_d7_an", an, 8'h7F);
        check_eq("frame_d7_seg", seg, 8'hF9);
        scan_pulse(5, 5);

        // Anti-tearing: data changes mid-frame only appear after the wrap.
        data    = 32'h0;
        dp_mask = 8'h00;
        repeat (8) scan_pulse(5, 5);
        repeat (3) scan_pulse(5, 5);
        data = 32'hFFFFFFFF;
        scan_pulse(5, 5);
        check_eq("tear_d4_seg", seg, 8'hC0);
        repeat (3) scan_pulse(5, 5);
        check_eq("tear_d7_seg", seg, 8'hC0);
        scan_pulse(5, 5);
        check_eq("tear_new_d0_seg", seg, 8'h8E);

        // Leading-zero blanking.
        data     = 32'h000000A5;
        lz_blank = 1'b1;
        repeat (8) scan_pulse(5, 5);
        check_eq("lz_d0_seg", seg, 8'h92);
        scan_pulse(5, 5);
        check_eq("lz_d1_an", an, 8'hFD);
        check_eq("lz_d1_seg", seg, 8'h88);
        scan_pulse(5, 5);
        check_eq("lz_d2_an", an, 8'hFF);
        check_eq("lz_d2_seg", seg, 8'hFF);
        repeat (5) scan_pulse(5, 5);
        check_eq("lz_d7_an", an, 8'hFF);
        scan_pulse(5, 5);
        data = 32'h0;
        repeat (8) scan_pulse(5, 5);
        check_eq("lz_zero_d0_an", an, 8'hFE);
        check_eq("lz_zero_d0_seg", seg, 8'hC0);
        scan_pulse(5, 5);
        check_eq("lz_zero_d1_an", an, 8'hFF);
        lz_blank = 1'b0;
        step();
        check_eq("lz_off_d1_an", an, 8'hFD);
        repeat (7) scan_pulse(5, 5);

        // Second scan edge two cycles into a blank: blank restarts, no SHOW in between.
        scan_rise();
        step();
        scan_clk = 1'b0;
        step();
        scan_rise();
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("tdb_blank_an", an, 8'hFF);
        end
        step();
        check_eq("tdb_show_an", an, 8'hFB);
        scan_clk = 1'b0;
        repeat (3) step();

        // Asynchronous reset mid-frame at idx 5.
        repeat (3) scan_pulse(5, 5);
        check_eq("pre_rst_an", an, 8'hDF);
        fd_base = fd_seen;
        do_reset(1'b0);
        check_eq("rst_no_fd", 8'(fd_seen - fd_base), 8'd0);
        step();
        check_eq("post_mid_rst_an", an, 8'hFE);

        // scan_clk high at reset release must not tick.
        do_reset(1'b1);
        repeat (7) step();
        check_eq("scan_high_no_tick_an", an, 8'hFE);
        scan_clk = 1'b0;
        repeat (3) step();
        scan_pulse(5, 5);
        check_eq("scan_high_then_tick_an", an, 8'hFD);

        // Randomized scan timing, data, masks, blanking and resets.
        for (int it = 0; it < 220; it++) begin
            if ($urandom_range(0, 3) == 0) data = $urandom >> ($urandom_range(0, 8) * 4);
            if ($urandom_range(0, 5) == 0) dp_mask = 8'($urandom);
            if ($urandom_range(0, 7) == 0) lz_blank = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
                if (scan_clk) begin
                    scan_clk = 1'b0;
                    step();
                end
            end
            scan_pulse($urandom_range(1, 8), $urandom_range(1, 8));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
